// File: rtl/syst_pkg.sv
// ============================================================================
// Module   : syst_pkg
// Brief    : Shared types and lane helpers for the systolic input feeder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package syst_pkg;

    localparam int LANES = 4;

    typedef enum logic [0:0] {
        LOAD   = 1'b0,
        STREAM = 1'b1
    } feeder_state_t;

    // Bit offset of a lane inside a packed row word; used for extract and insert.
    function automatic int lane_lsb(input int lane, input int x_width);
        return lane * x_width;
    endfunction

    // Lane k holds a real element on beat t when row t-k exists in the tile.
    function automatic logic lane_active(input int t, input int lane, input int rows);
        return ((t - lane) >= 0) && ((t - lane) < rows);
    endfunction

endpackage

`default_nettype wire

// File: rtl/syst_tile_buf.sv
// ============================================================================
// Module   : syst_tile_buf
// Brief    : TILE_ROWS x WORD tile store, one write port, per-lane row read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module syst_tile_buf
    import syst_pkg::*;
#(
    parameter int WORD      = 32,
    parameter int X_WIDTH   = 8,
    parameter int TILE_ROWS = 4,
    parameter int RW        = (TILE_ROWS > 1) ? $clog2(TILE_ROWS) : 1
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [RW-1:0]       wr_row_i,
    input  logic [WORD-1:0]     wr_data_i,
    input  logic [LANES*RW-1:0] rd_rows_i,
    output logic [WORD-1:0]     rd_word_o
);

    logic [WORD-1:0] r_mem [TILE_ROWS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[wr_row_i] <= wr_data_i;
        end
    end

    // Each lane reads its own row, so one access returns a full skewed beat.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign rd_word_o[lane_lsb(k, X_WIDTH) +: X_WIDTH] =
            r_mem[rd_rows_i[k*RW +: RW]][lane_lsb(k, X_WIDTH) +: X_WIDTH];
    end

endmodule

`default_nettype wire

// File: rtl/syst_feeder.sv
// ============================================================================
// Module   : syst_feeder
// Brief    : Buffers a tile of row words and replays it with diagonal skew.
//            Define SYST_FEEDER_PINGPONG_EN for two banks and gapless tiles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module syst_feeder
    import syst_pkg::*;
#(
    parameter int WORD      = 32,
    parameter int X_WIDTH   = 8,
    parameter int TILE_ROWS = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [WORD-1:0] s_data_i,
    input  logic            s_valid_i,
    output logic            s_ready_o,
    output logic [WORD-1:0] data_o,
    output logic            valid_o,
    output logic            valid_raw_1_o,
    output logic            valid_raw_2_o,
    output logic            valid_raw_3_o,
    output logic            valid_raw_4_o,
    output logic            tile_done_o
);

    localparam int RW        = (TILE_ROWS > 1) ? $clog2(TILE_ROWS) : 1;
    localparam int LAST_BEAT = TILE_ROWS + 2;
    localparam int TW        = $clog2(TILE_ROWS + 3);

    if (WORD != LANES * X_WIDTH) begin : g_bad_word
        $error("syst_feeder: WORD must equal 4*X_WIDTH");
    end
    if (TILE_ROWS < 1) begin : g_bad_rows
        $error("syst_feeder: TILE_ROWS must be at least 1");
    end

    feeder_state_t      r_state, w_state_nxt;
    logic [TW-1:0]      r_t, w_t_nxt;
    logic [RW-1:0]      r_wr_ptr;
    logic               w_xfer, w_load_last, w_last_beat, w_chain;
    logic [LANES*RW-1:0] w_rd_rows;
    logic [LANES-1:0]   w_act;
    logic [WORD-1:0]    w_rd_word, w_beat;
    logic [LANES-1:0]   r_raw;

    assign w_xfer      = s_valid_i & s_ready_o;
    assign w_load_last = w_xfer && (r_wr_ptr == RW'(TILE_ROWS - 1));
    assign w_last_beat = (r_state == STREAM) && (r_t == TW'(LAST_BEAT));

`ifdef SYST_FEEDER_PINGPONG_EN
    logic            r_wr_sel, r_rd_sel;
    logic [1:0]      r_full;
    logic [WORD-1:0] w_word0, w_word1;

    assign s_ready_o = ~r_full[r_wr_sel];
    // The idle bank may complete on the very edge the current stream ends.
    assign w_chain   = r_full[~r_rd_sel] | w_load_last;
    assign w_rd_word = r_rd_sel ? w_word1 : w_word0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_sel <= 1'b0;
            r_rd_sel <= 1'b0;
            r_full   <= 2'b00;
        end else begin
            if (w_load_last) begin
                r_full[r_wr_sel] <= 1'b1;
                r_wr_sel         <= ~r_wr_sel;
            end
            if (w_last_beat) begin
                r_full[r_rd_sel] <= 1'b0;
                r_rd_sel         <= ~r_rd_sel;
            end
        end
    end

    syst_tile_buf #(.WORD(WORD), .X_WIDTH(X_WIDTH), .TILE_ROWS(TILE_ROWS), .RW(RW)) u_bank0 (
        .clk_i     (clk_i),
        .we_i      (w_xfer & ~r_wr_sel),
        .wr_row_i  (r_wr_ptr),
        .wr_data_i (s_data_i),
        .rd_rows_i (w_rd_rows),
        .rd_word_o (w_word0)
    );

    syst_tile_buf #(.WORD(WORD), .X_WIDTH(X_WIDTH), .TILE_ROWS(TILE_ROWS), .RW(RW)) u_bank1 (
        .clk_i     (clk_i),
        .we_i      (w_xfer & r_wr_sel),
        .wr_row_i  (r_wr_ptr),
        .wr_data_i (s_data_i),
        .rd_rows_i (w_rd_rows),
        .rd_word_o (w_word1)
    );
`else
    assign s_ready_o = (r_state == LOAD);
    assign w_chain   = 1'b0;

    syst_tile_buf #(.WORD(WORD), .X_WIDTH(X_WIDTH), .TILE_ROWS(TILE_ROWS), .RW(RW)) u_bank0 (
        .clk_i     (clk_i),
        .we_i      (w_xfer),
        .wr_row_i  (r_wr_ptr),
        .wr_data_i (s_data_i),
        .rd_rows_i (w_rd_rows),
        .rd_word_o (w_rd_word)
    );
`endif

    // Lane k on beat t reads row t-k; inactive lanes read row 0 and are masked.
    always_comb begin
        w_rd_rows = '0;
        w_act     = '0;
        w_beat    = '0;
        for (int k = 0; k < LANES; k++) begin
            w_act[k] = lane_active(int'(r_t), k, TILE_ROWS);
            if (w_act[k]) begin
                w_rd_rows[k*RW +: RW] = RW'(int'(r_t) - k);
                w_beat[lane_lsb(k, X_WIDTH) +: X_WIDTH] =
                    w_rd_word[lane_lsb(k, X_WIDTH) +: X_WIDTH];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_t_nxt     = r_t;
        case (r_state)
            LOAD: begin
                if (w_load_last) begin
                    w_state_nxt = STREAM;
                    w_t_nxt     = '0;
                end
            end
            STREAM: begin
                if (w_last_beat) begin
                    w_t_nxt = '0;
                    if (!w_chain) begin
                        w_state_nxt = LOAD;
                    end
                end else begin
                    w_t_nxt = r_t + 1'b1;
                end
            end
            default: w_state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= LOAD;
            r_t      <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_t     <= w_t_nxt;
            if (w_xfer) begin
                r_wr_ptr <= w_load_last ? '0 : r_wr_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o      <= '0;
            valid_o     <= 1'b0;
            r_raw       <= '0;
            tile_done_o <= 1'b0;
        end else if (r_state == STREAM) begin
            data_o      <= w_beat;
            valid_o     <= 1'b1;
            r_raw       <= w_act;
            tile_done_o <= w_last_beat;
        end else begin
            data_o      <= '0;
            valid_o     <= 1'b0;
            r_raw       <= '0;
            tile_done_o <= 1'b0;
        end
    end

    assign valid_raw_1_o = r_raw[0];
    assign valid_raw_2_o = r_raw[1];
    assign valid_raw_3_o = r_raw[2];
    assign valid_raw_4_o = r_raw[3];

endmodule

`default_nettype wire

// File: tb/tb_syst_feeder.sv
// ============================================================================
// Module   : tb_syst_feeder
// Brief    : Directed self-checking bench for syst_feeder (4-row and 1-row tiles).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_syst_feeder;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] s_data_i = '0;
    logic        s_valid_i = 1'b0;
    logic        s_ready_o, valid_o, tile_done_o;
    logic        valid_raw_1_o, valid_raw_2_o, valid_raw_3_o, valid_raw_4_o;
    logic [31:0] data_o;

    logic [31:0] s1_data = '0;
    logic        s1_valid = 1'b0;
    logic        s1_ready, v1_o, d1_done;
    logic        r1_1, r1_2, r1_3, r1_4;
    logic [31:0] d1_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    syst_feeder #(.WORD(32), .X_WIDTH(8), .TILE_ROWS(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .s_data_i(s_data_i), .s_valid_i(s_valid_i),
        .s_ready_o(s_ready_o), .data_o(data_o), .valid_o(valid_o),
        .valid_raw_1_o(valid_raw_1_o), .valid_raw_2_o(valid_raw_2_o),
        .valid_raw_3_o(valid_raw_3_o), .valid_raw_4_o(valid_raw_4_o),
        .tile_done_o(tile_done_o)
    );

    syst_feeder #(.WORD(32), .X_WIDTH(8), .TILE_ROWS(1)) dut1 (
        .clk_i(clk), .rst_i(rst_i), .s_data_i(s1_data), .s_valid_i(s1_valid),
        .s_ready_o(s1_ready), .data_o(d1_o), .valid_o(v1_o),
        .valid_raw_1_o(r1_1), .valid_raw_2_o(r1_2),
        .valid_raw_3_o(r1_3), .valid_raw_4_o(r1_4),
        .tile_done_o(d1_done)
    );

    logic [31:0] tile_a [4] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
    logic [31:0] tile_b [4] = '{32'h14131211, 32'h18171615, 32'h1C1B1A19, 32'h201F1E1D};
    logic [31:0] exp_a  [7] = '{32'h00000001, 32'h00000205, 32'h00030609, 32'h04070A0D,
                                32'h080B0E00, 32'h0C0F0000, 32'h10000000};
    logic [31:0] exp_b  [7] = '{32'h00000011, 32'h00001215, 32'h00131619, 32'h14171A1D,
                                32'h181B1E00, 32'h1C1F0000, 32'h20000000};
    logic [3:0]  exp_raw [7] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] raw4();
        return {valid_raw_4_o, valid_raw_3_o, valid_raw_2_o, valid_raw_1_o};
    endfunction

    task automatic load_tile(input logic [31:0] w [4], input int gap);
        for (int i = 0; i < 4; i++) begin
            s_valid_i = 1'b1;
            s_data_i  = w[i];
            tick();
            s_valid_i = 1'b0;
            s_data_i  = 32'hDEADBEEF;
            if (i < 3) for (int g = 0; g < gap; g++) tick();
        end
    endtask

    task automatic check_stream(input string tag, input logic [31:0] exp_d [7]);
        check({tag, "_pre_valid"}, {31'd0, valid_o}, 32'd0);
        for (int b = 0; b < 7; b++) begin
            tick();
            check($sformatf("%s_data%0d", tag, b), data_o, exp_d[b]);
            check($sformatf("%s_raw%0d", tag, b), {28'd0, raw4()}, {28'd0, exp_raw[b]});
            check($sformatf("%s_valid%0d", tag, b), {31'd0, valid_o}, 32'd1);
            check($sformatf("%s_done%0d", tag, b), {31'd0, tile_done_o}, (b == 6) ? 32'd1 : 32'd0);
        end
        tick();
        check({tag, "_post_valid"}, {31'd0, valid_o}, 32'd0);
        check({tag, "_post_data"}, data_o, 32'd0);
    endtask

    initial begin
        logic [31:0] words [8];
        logic [31:0] q [$];
        logic [31:0] exp1 [4] = '{32'h000000AA, 32'h0000BB00, 32'h00CC0000, 32'hDD000000};
        int idx, rrun, rrun_max, vrun, vrun_max, n_done;
        logic rdy;

        tick();
        tick();
        check("rst_data", data_o, 32'd0);
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_raw", {28'd0, raw4()}, 32'd0);
        check("rst_done", {31'd0, tile_done_o}, 32'd0);
        check("rst_ready", {31'd0, s_ready_o}, 32'd1);
        rst_i = 1'b0;

        load_tile(tile_a, 0);
        check_stream("basic", exp_a);

        load_tile(tile_a, 2);
        check_stream("gaps", exp_a);

        // Reset while beat 3 is on the outputs, then a fresh tile.
        load_tile(tile_a, 0);
        for (int b = 0; b < 4; b++) tick();
        check("mid_beat3_data", data_o, exp_a[3]);
        rst_i = 1'b1;
        #1;
        check("mid_rst_data", data_o, 32'd0);
        check("mid_rst_valid", {31'd0, valid_o}, 32'd0);
        check("mid_rst_raw", {28'd0, raw4()}, 32'd0);
        #2;
        rst_i = 1'b0;
        load_tile(tile_b, 0);
        check_stream("after_rst", exp_b);

        // Source holds valid high across two tiles.
        for (int i = 0; i < 4; i++) begin
            words[i]     = tile_a[i];
            words[i + 4] = tile_b[i];
        end
        idx = 0; rrun = 0; rrun_max = 0; vrun = 0; vrun_max = 0; n_done = 0;
        s_valid_i = 1'b1;
        s_data_i  = words[0];
        rdy = s_ready_o;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            if (s_valid_i && rdy) idx++;
            #1;
            if (valid_o) begin
                q.push_back(data_o);
                vrun++;
            end else vrun = 0;
            if (vrun > vrun_max) vrun_max = vrun;
            if (!s_ready_o) rrun++;
            else rrun = 0;
            if (rrun > rrun_max) rrun_max = rrun;
            if (tile_done_o) n_done++;
            s_valid_i = (idx < 8);
            s_data_i  = (idx < 8) ? words[idx] : 32'd0;
            rdy = s_ready_o;
        end
        s_valid_i = 1'b0;
        check("bp_consumed", idx, 8);
        check("bp_beats", q.size(), 14);
        check("bp_done_pulses", n_done, 2);
        for (int i = 0; i < 14; i++) begin
            check($sformatf("bp_beat%0d", i), (i < q.size()) ? q[i] : 32'hFFFFFFFF,
                  (i < 7) ? exp_a[i] : exp_b[i - 7]);
        end
`ifdef SYST_FEEDER_PINGPONG_EN
        check("pp_valid_run", vrun_max, 14);
`else
        check("bp_ready_low_run", rrun_max, 7);
        check("bp_valid_run", vrun_max, 7);
`endif

        // Single-row tile.
        s1_valid = 1'b1;
        s1_data  = 32'hDDCCBBAA;
        tick();
        s1_valid = 1'b0;
        check("t1_pre_valid", {31'd0, v1_o}, 32'd0);
        for (int b = 0; b < 4; b++) begin
            tick();
            check($sformatf("t1_data%0d", b), d1_o, exp1[b]);
            check($sformatf("t1_raw%0d", b), {28'd0, r1_4, r1_3, r1_2, r1_1}, 32'd1 << b);
            check($sformatf("t1_done%0d", b), {31'd0, d1_done}, (b == 3) ? 32'd1 : 32'd0);
        end
        tick();
        check("t1_post_valid", {31'd0, v1_o}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/syst_feeder.md
Name: syst_feeder

Overview:
- Input stage directly upstream of the systolic-array/output-FIFO wrapper.
- Accepts a tile of TILE_ROWS packed row words over a valid/ready stream and buffers the whole tile.
- Replays the tile to the array with diagonal skew: lane k is delayed k cycles.
- Drives the array's data_i, valid_i and per-row valid_raw_1..4 inputs.

Parameters:
- WORD, 32, width of packed row word; must equal 4*X_WIDTH (elaboration-time assertion).
- X_WIDTH, 8, element width; lane k occupies bits [k*X_WIDTH +: X_WIDTH].
- TILE_ROWS, 4, words per tile (>=1); skewed stream length is TILE_ROWS+3 beats.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- s_data_i  in  WORD  input row word
- s_valid_i  in  1  input word valid
- s_ready_o  out  1  feeder can accept a word
- data_o  out  WORD  skewed word to array; inactive lanes are 0
- valid_o  out  1  high on every beat of a skewed stream
- valid_raw_1_o..valid_raw_4_o  out  1 each  lane 0..3 carries a real element this beat
- tile_done_o  out  1  one-cycle pulse on the last beat of a tile

Behaviour:
- Reset, async: state LOAD, wr_ptr=0, beat counter t=0.
  - data_o=0, valid_o=0, valid_raw_*=0, tile_done_o=0.
  - s_ready_o=1 (combinational: state==LOAD).
- Handshake: transfer occurs when s_valid_i & s_ready_o at clk edge. s_data_i is ignored otherwise.
- LOAD:
  - Each transfer writes buf[wr_ptr] and increments wr_ptr.
  - Transfer at wr_ptr==TILE_ROWS-1 sets wr_ptr=0 and moves to STREAM with t=0.
  - s_ready_o falls in the next cycle.
- STREAM: all outputs are registered. Beat t (t=0..TILE_ROWS+2) appears t+1 cycles after the last load transfer.
  - Lane k = buf[t-k][k] if 0<=t-k<TILE_ROWS, else 0.
  - valid_raw_(k+1)_o = (0<=t-k<TILE_ROWS).
  - valid_o=1 for every beat.
  - tile_done_o=1 only on beat TILE_ROWS+2.
- After the final beat, the state returns to LOAD. Outputs return to 0 the next cycle.
- There is no backpressure from downstream; a stream is never stalled once started.
- s_valid_i high while s_ready_o=0: the word is held by the source and not consumed.
- Reset mid-load or mid-stream: partial tile discarded, outputs cleared immediately (async).
- TILE_ROWS=1: stream is 4 beats, one element per lane on successive beats.

Optional Feature:
- Macro SYST_FEEDER_PINGPONG_EN.
- Defined:
  - Two buffer banks. Loading continues into the idle bank while the other streams; s_ready_o = idle bank not full.
  - If the idle bank is full when a stream ends, its beat 0 follows the previous last beat with no gap, valid_o continuously 1.
  - Otherwise the block waits in LOAD as usual.
  - Bank select toggles per tile.
- Undefined:
  - Single bank; s_ready_o=0 throughout STREAM.
  - Minimum one idle cycle between tiles.

Decomposition:
- Package syst_pkg: feeder_state_t enum {LOAD, STREAM}, LANES=4 constant, lane extract/insert helper function.
- Sub-module syst_tile_buf holds TILE_ROWS x WORD storage:
  - One write port.
  - Combinational read of any [row][lane].
  - Instantiated once, or twice under SYST_FEEDER_PINGPONG_EN.
- The FSM and skew logic stay in syst_feeder.

Test Plan:
- Basic skew:
  - Stimulus: reset, then load 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D back-to-back.
  - Expected data_o: 0x00000001, 0x00000205, 0x00030609, 0x04070A0D, 0x080B0E00, 0x0C0F0000, 0x10000000.
  - Expected valid_raw[4:1]: 0001, 0011, 0111, 1111, 1110, 1100, 1000.
  - tile_done_o on the 7th beat only.
- Source gaps: same tile with s_valid_i toggling 1,0,0,1,... -> identical 7-beat output; beat 0 appears one cycle after the 4th transfer.
- Backpressure: s_valid_i held high throughout -> s_ready_o=0 for exactly 7 cycles of STREAM; no word lost or duplicated across two tiles.
- Reset during beat 3 -> all outputs 0 in the same cycle; next tile streams correctly from beat 0.
- TILE_ROWS=1, word 0xDDCCBBAA -> beats 0x000000AA, 0x0000BB00, 0x00CC0000, 0xDD000000.
- SYST_FEEDER_PINGPONG_EN, two tiles streamed continuously -> valid_o high for 14 consecutive cycles; second tile's beat 0 follows tile_done_o directly.
